// File: rtl/arbiter_4_rr.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index and
// bounded tenure; a holder is re-arbitrated after MAX_HOLD consecutive cycles.
module arbiter_4_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } mode_t;

    mode_t          mode_q, mode_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     cur_q, cur_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     gnt_idx_q, gnt_idx_d;
    logic           gnt_valid_q, gnt_valid_d;

    logic           release_w;
    logic [2:0]     win_w;

    // Returns {found, index}: first set bit of r scanning upward from start, wrapping.
    function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        release_w   = 1'b0;
        win_w       = 3'b000;

        case (mode_q)
            IDLE: begin
                win_w = find_winner(req, ptr_q);
                if (win_w[2]) begin
                    mode_d      = GRANT;
                    cur_d       = win_w[1:0];
                    cnt_d       = CW'(1);
                    gnt_d       = 4'b0001 << win_w[1:0];
                    gnt_idx_d   = win_w[1:0];
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                release_w = !req[cur_q] || (cnt_q == CW'(MAX_HOLD));
                if (!release_w) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // The outgoing owner is scanned last so it only wins when alone.
                    ptr_d = cur_q + 2'd1;
                    win_w = find_winner(req, cur_q + 2'd1);
                    if (win_w[2]) begin
                        cur_d       = win_w[1:0];
                        cnt_d       = CW'(1);
                        gnt_d       = 4'b0001 << win_w[1:0];
                        gnt_idx_d   = win_w[1:0];
                        gnt_valid_d = 1'b1;
                    end else begin
                        mode_d      = IDLE;
                        cnt_d       = '0;
                        gnt_d       = 4'b0000;
                        gnt_idx_d   = 2'd0;
                        gnt_valid_d = 1'b0;
                    end
                end
            end
            default: mode_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= IDLE;
            ptr_q       <= 2'd0;
            cur_q       <= 2'd0;
            cnt_q       <= '0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arbiter_4_rr.sv
// Directed bench for arbiter_4_rr: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_arbiter_4_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [1:0] gnt_idx1;
    logic       gnt_valid1;

    int n_pass;
    int n_total;

    arbiter_4_rr #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    arbiter_4_rr #(.MAX_HOLD(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req1),
        .gnt      (gnt1),
        .gnt_idx  (gnt_idx1),
        .gnt_valid(gnt_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
            $display("FAIL reset_state: got v=%b idx=%0d gnt=%b, want v=0 idx=0 gnt=0000", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
        req = 4'b0100;
        tick();
        tick();
        n_total++;
        if (gnt !== 4'b0100) begin
            $display("FAIL reset_pre_grant: got gnt=%b, want 0100", gnt);
        end else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
            $display("FAIL reset_async: got v=%b idx=%0d gnt=%b, want all zero", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
        req = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 2'd0, 4'b0001}) begin
            $display("FAIL reset_first_grant: got v=%b idx=%0d gnt=%b, want v=1 idx=0 gnt=0001", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 2'd2, 4'b0100}) begin
            $display("FAIL single_grant: got v=%b idx=%0d gnt=%b, want v=1 idx=2 gnt=0100", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
        tick();
        tick();
        req = 4'b0000;
        tick();
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
            $display("FAIL single_drop: got v=%b idx=%0d gnt=%b, want all zero", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_idx = 2'((c / 4) % 4);
            exp_gnt = 4'b0001 << exp_idx;
            n_total++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b1, exp_idx, exp_gnt}) begin
                $display("FAIL contention_c%0d: got v=%b idx=%0d gnt=%b, want v=1 idx=%0d gnt=%b",
                         c, gnt_valid, gnt_idx, gnt, exp_idx, exp_gnt);
            end else n_pass++;
        end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b0011;
        tick();
        n_total++;
        if (gnt !== 4'b0001) begin
            $display("FAIL handoff_initial: got gnt=%b, want 0001", gnt);
        end else n_pass++;
        tick();
        req = 4'b0010;
        tick();
        n_total++;
        if ({gnt_idx, gnt} !== {2'd1, 4'b0010}) begin
            $display("FAIL handoff_switch: got idx=%0d gnt=%b, want idx=1 gnt=0010", gnt_idx, gnt);
        end else n_pass++;
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (gnt !== 4'b0010) begin
                $display("FAIL handoff_tenure_%0d: got gnt=%b, want 0010", c, gnt);
            end else n_pass++;
        end
        tick();
        n_total++;
        if (gnt !== 4'b0001) begin
            $display("FAIL handoff_timeout: got gnt=%b, want 0001", gnt);
        end else n_pass++;
    endtask

    task automatic test_sole_timeout();
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_total++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 2'd3, 4'b1000}) begin
                $display("FAIL sole_c%0d: got v=%b idx=%0d gnt=%b, want v=1 idx=3 gnt=1000", c, gnt_valid, gnt_idx, gnt);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1000;
        tick();
        n_total++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 2'd3, 4'b1000}) begin
            $display("FAIL swap_grant: got v=%b idx=%0d gnt=%b, want v=1 idx=3 gnt=1000", gnt_valid, gnt_idx, gnt);
        end else n_pass++;
        n_total++;
        if (dut.ptr_q !== 2'd2) begin
            $display("FAIL swap_ptr: got ptr=%0d, want 2", dut.ptr_q);
        end else n_pass++;
        // Owner 3 drops: pointer moves to 0, so requester 0 wins next.
        req = 4'b0111;
        tick();
        n_total++;
        if (gnt !== 4'b0001) begin
            $display("FAIL swap_next: got gnt=%b, want 0001", gnt);
        end else n_pass++;

        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        n_total++;
        if ({gnt_valid, gnt} !== 5'b0) begin
            $display("FAIL idle_after_drop: got v=%b gnt=%b, want v=0 gnt=0000", gnt_valid, gnt);
        end else n_pass++;
        req = 4'b0111;
        tick();
        n_total++;
        if ({gnt_idx, gnt} !== {2'd2, 4'b0100}) begin
            $display("FAIL idle_ptr_grant: got idx=%0d gnt=%b, want idx=2 gnt=0100", gnt_idx, gnt);
        end else n_pass++;
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_gnt;
        do_reset();
        req1 = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_gnt = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            n_total++;
            if ({gnt_valid1, gnt1} !== {1'b1, exp_gnt}) begin
                $display("FAIL hold1_c%0d: got v=%b gnt=%b, want v=1 gnt=%b", c, gnt_valid1, gnt1, exp_gnt);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        req1    = 4'b0000;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_sole_timeout();
        test_back_to_back();
        test_max_hold_one();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
